// File: rtl/wb_common_pkg.sv
// Common Wishbone bundle types shared by bus peripherals.
// Controller request and peripheral response structs.
package wb_common_pkg;

  typedef struct packed {
    logic       stb;
    logic       we;
    logic [3:0] adr;
    logic [7:0] dat;
  } iWishbone_Ctrl;

  typedef struct packed {
    logic       ack;
    logic [7:0] dat;
  } iWishbone_Peri;

endpackage

// File: rtl/wb_pwm_leds_pkg.sv
// Shared constants and types for the wb_pwm_leds peripheral.
// gamma() backs the WB_PWM_LEDS_GAMMA_EN build option.
package pkg_wb_pwm_leds;

  localparam logic [3:0] ADR_CTRL     = 4'd8;
  localparam logic [3:0] ADR_PRESCALE = 4'd9;
  localparam logic [3:0] ADR_PHASE    = 4'd10;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_INV = 1;

  typedef logic [7:0] duty_t;

  function automatic duty_t gamma(input duty_t d);
    logic [15:0] p;
    p = 16'(d) * 16'(d);
    return p[15:8];
  endfunction

endpackage

// File: rtl/wb_pwm_leds_timebase.sv
// Prescaler and 8-bit PWM phase counter.
// Held at zero while disabled; wrap marks the 255->0 tick.
module wb_pwm_leds_timebase #(
  parameter int pPrescaleW = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [pPrescaleW-1:0] prescale,
  output logic [7:0]            pwm_cnt,
  output logic                  tick,
  output logic                  wrap
);

  logic [pPrescaleW-1:0] pre;

  // >= so a shrunk prescale wraps the counter at once
  assign tick = en && (pre >= prescale);
  assign wrap = tick && (pwm_cnt == 8'hFF);

  // prescaler and phase counter advance
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      pre     <= '0;
      pwm_cnt <= '0;
    end else if (tick) begin
      pre     <= '0;
      pwm_cnt <= pwm_cnt + 8'd1;
    end else begin
      pre <= pre + pPrescaleW'(1);
    end
  end

endmodule

// File: rtl/wb_pwm_leds.sv
// Wishbone LED PWM responder: duty, control, prescale regs.
// Option macro WB_PWM_LEDS_GAMMA_EN: gamma-corrected shadows.
module wb_pwm_leds
  import wb_common_pkg::*;
  import pkg_wb_pwm_leds::*;
#(
  parameter int pLeds      = 8,
  parameter int pPrescaleW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  iWishbone_Ctrl    wb_c,
  output iWishbone_Peri    wb_p,
  output logic [pLeds-1:0] leds
);

  duty_t                 duty     [pLeds];
  duty_t                 shadow   [pLeds];
  duty_t                 shadow_d [pLeds];
  logic [1:0]            ctrl;
  logic [pPrescaleW-1:0] prescale;
  logic [7:0]            pwm_cnt;
  logic                  tick;
  logic                  wrap;
  logic                  en;
  logic                  inv;
  logic                  wr;
  duty_t                 rd_dat;
  logic [pLeds-1:0]      raw;

  assign en  = ctrl[CTRL_EN];
  assign inv = ctrl[CTRL_INV];
  assign wr  = wb_c.stb && wb_c.we;

  wb_pwm_leds_timebase #(
    .pPrescaleW(pPrescaleW)
  ) u_timebase (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .prescale(prescale),
    .pwm_cnt (pwm_cnt),
    .tick    (tick),
    .wrap    (wrap)
  );

  // register file writes, committed with the ack edge
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl     <= '0;
      prescale <= '0;
      for (int i = 0; i < pLeds; i++)
        duty[i] <= '0;
    end else if (wr) begin
      for (int i = 0; i < pLeds; i++)
        if (wb_c.adr == 4'(i))
          duty[i] <= wb_c.dat;
      if (wb_c.adr == ADR_CTRL)
        ctrl <= wb_c.dat[1:0];
      if (wb_c.adr == ADR_PRESCALE)
        prescale <= pPrescaleW'(wb_c.dat);
    end
  end

  // read mux; unmapped addresses return 0
  always_comb begin
    rd_dat = '0;
    case (wb_c.adr)
      ADR_CTRL:     rd_dat = {6'b0, ctrl};
      ADR_PRESCALE: rd_dat = 8'(prescale);
      ADR_PHASE:    rd_dat = pwm_cnt;
      default: begin
        for (int i = 0; i < pLeds; i++)
          if (wb_c.adr == 4'(i))
            rd_dat = duty[i];
      end
    endcase
  end

  // single-cycle ack; data only on read acks
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_p.ack <= 1'b0;
      wb_p.dat <= '0;
    end else begin
      wb_p.ack <= wb_c.stb;
      wb_p.dat <= (wb_c.stb && !wb_c.we) ? rd_dat : '0;
    end
  end

  // value a shadow takes when it reloads
  always_comb begin
    for (int i = 0; i < pLeds; i++) begin
`ifdef WB_PWM_LEDS_GAMMA_EN
      shadow_d[i] = gamma(duty[i]);
`else
      shadow_d[i] = duty[i];
`endif
    end
  end

  // shadows track while idle, else reload only at wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < pLeds; i++)
        shadow[i] <= '0;
    end else if (!en || wrap) begin
      for (int i = 0; i < pLeds; i++)
        shadow[i] <= shadow_d[i];
    end
  end

  // per-LED compare against the phase counter
  always_comb begin
    raw = '0;
    for (int i = 0; i < pLeds; i++)
      raw[i] = pwm_cnt < shadow[i];
  end

  // registered drive keeps the outputs glitch-free
  always_ff @(posedge clk) begin
    if (rst || !en)
      leds <= '0;
    else
      leds <= raw ^ {pLeds{inv}};
  end

endmodule

// File: tb/tb_wb_pwm_leds.sv
// Directed self-checking bench for wb_pwm_leds.
// Follows WB_PWM_LEDS_GAMMA_EN for the gamma expectations.
module tb_wb_pwm_leds;
  import wb_common_pkg::*;

  logic          clk;
  logic          rst;
  iWishbone_Ctrl wb_c;
  iWishbone_Peri wb_p;
  logic [7:0]    leds;

  int n_cmp;
  int n_bad;

  int cyc;
  int run;
  logic prev;
  int rise_q[$];
  int width_q[$];
  int other_on;

  wb_pwm_leds #(
    .pLeds     (8),
    .pPrescaleW(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .wb_c(wb_c),
    .wb_p(wb_p),
    .leds(leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // leds[0] pulse monitor, sampled mid-cycle
  initial begin
    cyc = 0;
    run = 0;
    prev = 1'b0;
    other_on = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (leds[0] && !prev)
        rise_q.push_back(cyc);
      if (leds[0])
        run++;
      if (!leds[0] && prev) begin
        width_q.push_back(run);
        run = 0;
      end
      if (leds[7:1] != 7'd0)
        other_on++;
      prev = leds[0];
    end
  end

  task automatic mon_clear();
    rise_q.delete();
    width_q.delete();
    run = 0;
    prev = leds[0];
    other_on = 0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // one request; returns sampled ack-cycle response
  task automatic bus(input logic we,
                     input logic [3:0] adr,
                     input logic [7:0] dat,
                     output logic ack,
                     output logic [7:0] rd);
    wb_c.stb = 1'b1;
    wb_c.we  = we;
    wb_c.adr = adr;
    wb_c.dat = dat;
    @(posedge clk);
    #1;
    ack = wb_p.ack;
    rd  = wb_p.dat;
    wb_c.stb = 1'b0;
    wb_c.we  = 1'b0;
  endtask

  task automatic test_reset();
    logic a;
    logic [7:0] d;
    logic [3:0] adrs [4];
    adrs[0] = 4'd0;
    adrs[1] = 4'd8;
    adrs[2] = 4'd9;
    adrs[3] = 4'd10;
    rst = 1'b1;
    wb_c = '0;
    cycles(3);
    rst = 1'b0;
    n_cmp++;
    if (wb_p.ack !== 1'b0 || leds !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_out: ack=%b leds=%h want 0/00",
               wb_p.ack, leds);
    end
    foreach (adrs[k]) begin
      bus(1'b0, adrs[k], 8'h00, a, d);
      n_cmp++;
      if (a !== 1'b1 || d !== 8'd0) begin
        n_bad++;
        $display("FAIL reset_read adr=%0d: ack=%b dat=%h want 1/00",
                 adrs[k], a, d);
      end
      cycles(1);
      n_cmp++;
      if (wb_p.ack !== 1'b0 || leds !== 8'd0) begin
        n_bad++;
        $display("FAIL reset_ack_drop adr=%0d: ack=%b leds=%h",
                 adrs[k], wb_p.ack, leds);
      end
    end
  endtask

  task automatic test_pwm();
    logic a;
    logic [7:0] d;
    bus(1'b1, 4'd0, 8'd64, a, d);
    n_cmp++;
    if (a !== 1'b1 || d !== 8'd0) begin
      n_bad++;
      $display("FAIL write_ack: ack=%b dat=%h want 1/00", a, d);
    end
    bus(1'b1, 4'd9, 8'd0, a, d);
    mon_clear();
    bus(1'b1, 4'd8, 8'd1, a, d);
    cycles(700);
    n_cmp++;
    if (width_q.size() < 2 || rise_q.size() < 2) begin
      n_bad++;
      $display("FAIL pwm_pulses: widths=%0d rises=%0d want >=2",
               width_q.size(), rise_q.size());
    end else begin
      n_cmp++;
      if (width_q[0] !== 64 || width_q[1] !== 64) begin
        n_bad++;
        $display("FAIL pwm_width: %0d,%0d want 64,64",
                 width_q[0], width_q[1]);
      end
      n_cmp++;
      if (rise_q[1] - rise_q[0] !== 256) begin
        n_bad++;
        $display("FAIL pwm_period: %0d want 256",
                 rise_q[1] - rise_q[0]);
      end
    end
    n_cmp++;
    if (other_on !== 0) begin
      n_bad++;
      $display("FAIL pwm_others: %0d cycles on want 0", other_on);
    end
  endtask

  task automatic test_shadow();
    logic a;
    logic [7:0] d;
    int t;
    mon_clear();
    t = 0;
    while (rise_q.size() == 0 && t < 300) begin
      cycles(1);
      t++;
    end
    n_cmp++;
    if (rise_q.size() == 0) begin
      n_bad++;
      $display("FAIL shadow_rise: no rise in %0d cycles", t);
    end else begin
      width_q.delete();
      bus(1'b1, 4'd0, 8'd200, a, d);
      bus(1'b0, 4'd0, 8'd0, a, d);
      n_cmp++;
      if (a !== 1'b1 || d !== 8'd200) begin
        n_bad++;
        $display("FAIL shadow_readback: ack=%b dat=%0d want 1/200",
                 a, d);
      end
      cycles(600);
      n_cmp++;
      if (width_q.size() < 2 || rise_q.size() < 2) begin
        n_bad++;
        $display("FAIL shadow_pulses: widths=%0d rises=%0d",
                 width_q.size(), rise_q.size());
      end else begin
        n_cmp++;
        if (width_q[0] !== 64 || width_q[1] !== 200) begin
          n_bad++;
          $display("FAIL shadow_width: %0d,%0d want 64,200",
                   width_q[0], width_q[1]);
        end
        n_cmp++;
        if (rise_q[1] - rise_q[0] !== 256) begin
          n_bad++;
          $display("FAIL shadow_period: %0d want 256",
                   rise_q[1] - rise_q[0]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    wb_c.stb = 1'b1;
    wb_c.we  = 1'b1;
    wb_c.adr = 4'd1;
    wb_c.dat = 8'h5A;
    cycles(1);
    n_cmp++;
    if (wb_p.ack !== 1'b1 || wb_p.dat !== 8'h00) begin
      n_bad++;
      $display("FAIL b2b_1: ack=%b dat=%h want 1/00",
               wb_p.ack, wb_p.dat);
    end
    wb_c.we  = 1'b0;
    wb_c.dat = 8'h00;
    cycles(1);
    n_cmp++;
    if (wb_p.ack !== 1'b1 || wb_p.dat !== 8'h5A) begin
      n_bad++;
      $display("FAIL b2b_2: ack=%b dat=%h want 1/5a",
               wb_p.ack, wb_p.dat);
    end
    wb_c.adr = 4'd15;
    cycles(1);
    n_cmp++;
    if (wb_p.ack !== 1'b1 || wb_p.dat !== 8'h00) begin
      n_bad++;
      $display("FAIL b2b_3: ack=%b dat=%h want 1/00",
               wb_p.ack, wb_p.dat);
    end
    wb_c.stb = 1'b0;
    cycles(1);
    n_cmp++;
    if (wb_p.ack !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_end: ack=%b want 0", wb_p.ack);
    end
  endtask

  task automatic test_inv();
    logic a;
    logic [7:0] d;
    int zeros;
    bus(1'b1, 4'd2, 8'd0, a, d);
    bus(1'b1, 4'd8, 8'd3, a, d);
    cycles(2);
    zeros = 0;
    for (int i = 0; i < 300; i++) begin
      if (leds[2] !== 1'b1)
        zeros++;
      cycles(1);
    end
    n_cmp++;
    if (zeros !== 0) begin
      n_bad++;
      $display("FAIL inv_led2: %0d cycles off want 0", zeros);
    end
    bus(1'b1, 4'd8, 8'd2, a, d);
    cycles(2);
    n_cmp++;
    if (leds !== 8'd0) begin
      n_bad++;
      $display("FAIL disable_leds: %h want 00", leds);
    end
    bus(1'b0, 4'd10, 8'd0, a, d);
    n_cmp++;
    if (a !== 1'b1 || d !== 8'd0) begin
      n_bad++;
      $display("FAIL disable_phase: ack=%b dat=%h want 1/00", a, d);
    end
    bus(1'b0, 4'd8, 8'd0, a, d);
    n_cmp++;
    if (d !== 8'd2) begin
      n_bad++;
      $display("FAIL ctrl_read: %h want 02", d);
    end
  endtask

  task automatic test_reset_cancel();
    logic a;
    logic [7:0] d;
    rst = 1'b1;
    wb_c.stb = 1'b1;
    wb_c.we  = 1'b1;
    wb_c.adr = 4'd3;
    wb_c.dat = 8'h77;
    cycles(1);
    wb_c.stb = 1'b0;
    wb_c.we  = 1'b0;
    n_cmp++;
    if (wb_p.ack !== 1'b0) begin
      n_bad++;
      $display("FAIL cancel_ack: ack=%b want 0", wb_p.ack);
    end
    cycles(1);
    rst = 1'b0;
    bus(1'b0, 4'd3, 8'd0, a, d);
    n_cmp++;
    if (a !== 1'b1 || d !== 8'd0) begin
      n_bad++;
      $display("FAIL cancel_reg: ack=%b dat=%h want 1/00", a, d);
    end
    bus(1'b0, 4'd0, 8'd0, a, d);
    n_cmp++;
    if (d !== 8'd0 || leds !== 8'd0) begin
      n_bad++;
      $display("FAIL cancel_duty0: dat=%h leds=%h want 00/00",
               d, leds);
    end
  endtask

  task automatic test_gamma_prescale();
    logic a;
    logic [7:0] d;
    int exp_w;
`ifdef WB_PWM_LEDS_GAMMA_EN
    exp_w = 2 * 64;
`else
    exp_w = 2 * 128;
`endif
    bus(1'b1, 4'd0, 8'd128, a, d);
    bus(1'b1, 4'd9, 8'd1, a, d);
    bus(1'b0, 4'd0, 8'd0, a, d);
    n_cmp++;
    if (d !== 8'd128) begin
      n_bad++;
      $display("FAIL gamma_readback: %0d want 128", d);
    end
    mon_clear();
    bus(1'b1, 4'd8, 8'd1, a, d);
    cycles(1300);
    n_cmp++;
    if (width_q.size() < 2 || rise_q.size() < 2) begin
      n_bad++;
      $display("FAIL gamma_pulses: widths=%0d rises=%0d",
               width_q.size(), rise_q.size());
    end else begin
      n_cmp++;
      if (width_q[0] !== exp_w || width_q[1] !== exp_w) begin
        n_bad++;
        $display("FAIL gamma_width: %0d,%0d want %0d",
                 width_q[0], width_q[1], exp_w);
      end
      n_cmp++;
      if (rise_q[1] - rise_q[0] !== 512) begin
        n_bad++;
        $display("FAIL prescale_period: %0d want 512",
                 rise_q[1] - rise_q[0]);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    wb_c = '0;
    test_reset();
    test_pwm();
    test_shadow();
    test_back_to_back();
    test_inv();
    test_reset_cancel();
    test_gamma_prescale();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_pwm_leds.md
Name: wb_pwm_leds

Overview:
Wishbone responder that owns the board LEDs. Exposes per-LED 8-bit duty registers plus control and prescale registers, and generates glitch-free PWM on each LED output. It is the active peripheral end of the same controller/peripheral bus pair that the passive bus-activity LED monitor only observes.

Parameters:
pLeds, 8, number of LED outputs and duty registers (1..8).
pPrescaleW, 8, width of the PRESCALE register and the prescaler counter.

Ports:
clk  input  1  system clock.
rst  input  1  synchronous, active-high reset.
wb_c  input  iWishbone_Ctrl  controller request; fields stb (1), we (1), adr (4), dat (8).
wb_p  output  iWishbone_Peri  peripheral response; fields ack (1), dat (8).
leds  output  pLeds  PWM LED drive, 1 = on.

Behaviour:
- Register map (adr): 0..pLeds-1 DUTY[i] rw; 8 CTRL rw (bit0 EN, bit1 INV, others read 0); 9 PRESCALE rw; 10 PHASE ro (current pwm_cnt); all other addresses: write ignored, read 0. DUTY addresses >= pLeds behave as unmapped.
- Handshake: stb is a one-cycle request. Sampled stb at edge N gives ack=1 for exactly the cycle after edge N, so latency is 1. stb in consecutive cycles gives ack in consecutive cycles. No wait states; every request is acked, including unmapped ones.
- wb_p.dat holds read data during the ack cycle and is 0 otherwise, including for write acks. Write data is committed on the same edge that sets ack.
- Reset: ack=0, wb_p.dat=0, leds=0, DUTY/shadow=0, CTRL=0, PRESCALE=0, prescaler=0, pwm_cnt=0. Reset during a pending ack cancels it: no ack is issued and the write is not committed.
- Prescaler: counts 0..PRESCALE, then emits a tick and returns to 0. With PRESCALE=0 there is a tick every cycle. A PRESCALE write takes effect immediately; if the counter is above the new value, it wraps to 0 on the next cycle with a tick.
- PWM counter: 8-bit pwm_cnt increments on each tick, 255 -> 0 wrap. Period = 256*(PRESCALE+1) cycles.
- Shadowing: each LED compares against shadow[i], not DUTY[i]. All shadows load from DUTY on the tick that wraps pwm_cnt 255->0. While EN=0, shadows track DUTY every cycle.
- Compare: raw[i] = (pwm_cnt < shadow[i]). Duty 0 is always off; 255 is on for 255 of 256 steps.
- Output (registered, 1-cycle delay from compare): EN=0 gives leds=0 and holds prescaler and pwm_cnt at 0. EN=1 gives leds = raw XOR {pLeds{INV}}.
- EN 0->1: counting starts from 0 on the following cycle.
- A simultaneous DUTY write and wrap tick: the shadow loads the old DUTY value; the new value applies next period.

Optional Feature:
- Macro WB_PWM_LEDS_GAMMA_EN.
- Defined: the shadow loads gamma(DUTY) = (DUTY*DUTY)>>8, a 16-bit product truncated to 8 bits, using one multiplier per LED or a shared sequential multiplier finishing within the same tick window. Examples: gamma(255)=254, gamma(128)=64, gamma(15)=0.
- Undefined: the shadow loads DUTY unchanged.
- Register readback always returns the raw DUTY value in both cases.

Decomposition:
- Shared package pkg_wb_pwm_leds: address constants (ADR_CTRL=8, ADR_PRESCALE=9, ADR_PHASE=10), CTRL bit indices, duty typedef (logic[7:0]).
- The iWishbone_Ctrl/iWishbone_Peri types remain in the existing common Wishbone package.
- One sub-module: wb_pwm_leds_timebase (prescaler + pwm_cnt + wrap/tick strobes). The register file and compare logic stay in the top module.

Test Plan:
- Reset, then read adr 0, 8, 9, 10 -> each ack exactly 1 cycle after stb, dat=0; leds=0 throughout.
- Write DUTY[0]=64, PRESCALE=0, CTRL=1 -> leds[0] high for 64 of every 256 cycles, others 0, period exactly 256 cycles.
- Mid-period write DUTY[0]=200 -> high time stays 64 until the next 255->0 wrap, then becomes 200. Readback gives 200 immediately.
- stb on 3 consecutive cycles (write adr 1, read adr 1, read adr 15) -> 3 consecutive acks; second read returns the written value, third returns 0.
- CTRL=3 (EN+INV), DUTY[2]=0 -> leds[2] constantly 1. Then CTRL=2 -> all leds 0 and PHASE reads 0.
- Reset asserted the cycle after a write stb -> no ack, register reads 0 after reset. With WB_PWM_LEDS_GAMMA_EN, DUTY=128 gives 64 high cycles per period.
